dmw_layer_sequencer: RTL and testbench

Per-layer controller for the multi-channel write data mover. It accepts one layer descriptor and replays it as the mover's three 32-bit config words, then snoops the DataMover S2MM status stream to count completed row commands. It raises a one-cycle done pulse when all rows have completed, and flags status errors, stalls and stray completions. It sits between the layer scheduler and the mover's config and status ports.

---
 rtl/dmw_seq_pkg.sv | 41 ++++
 rtl/dmw_seq_watchdog.sv | 32 +++
 rtl/dmw_layer_sequencer.sv | 177 +++++++++++++++++
 tb/tb_dmw_layer_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmw_seq_pkg.sv
// Shared types and constants for the data-mover layer sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dmw_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG0 = 3'd1,
        ST_CFG1 = 3'd2,
        ST_CFG2 = 3'd3,
        ST_RUN  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } seq_state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_DESC = 3'd1;
    localparam logic [2:0] ERR_STS      = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_STRAY    = 3'd4;

    // S2MM status byte: bit7 = OKAY, bits 6:4 = SLVERR/DECERR/INTERR
    localparam int STS_OKAY_BIT = 7;
    localparam int STS_ERR_HI   = 6;
    localparam int STS_ERR_LO   = 4;

    localparam logic [3:0] DMW_ST_CONFIG = 4'b0000;

    // Descriptor as it arrives on the 96-bit bus: {word2, word1, word0}
    typedef struct packed {
        logic [31:0] word2;
        logic [31:0] word1;
        logic [31:0] word0;
    } desc_t;

    // Effective row count: halved when the mover subsamples rows
    function automatic logic [11:0] calc_h_eff(input logic sw, input logic [11:0] img_h);
        return sw ? {1'b0, img_h[11:1]} : img_h;
    endfunction

endpackage

// File: rtl/dmw_seq_watchdog.sv
// Loadable down-counter flagging TIMEOUT_CYC enabled cycles without a kick.
// Latency: expired is combinational on the last counted cycle.
// Backpressure: none; a kick in the same cycle masks expiry.
module dmw_seq_watchdog #(
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;

    // Reload on kick, otherwise count down while enabled and stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LOAD;
        end else if (kick) begin
            cnt_q <= LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expired = en && !kick && (cnt_q == CW'(1));

endmodule

// File: rtl/dmw_layer_sequencer.sv
// Replays one layer descriptor as three mover config words, then counts S2MM completions.
// Latency: config word 0 one cycle after descriptor accept; done one cycle after final status.
// Backpressure: config words held stable until accepted; descriptor only accepted in IDLE.
module dmw_layer_sequencer
    import dmw_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1048576,
    parameter int CNT_W       = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [95:0]      s_axis_desc_tdata,
    input  logic             s_axis_desc_tvalid,
    output logic             s_axis_desc_tready,
    output logic [31:0]      m_axis_dmwconfig_tdata,
    output logic             m_axis_dmwconfig_tvalid,
    input  logic             m_axis_dmwconfig_tready,
    input  logic [7:0]       snoop_sts_tdata,
    input  logic             snoop_sts_tvalid,
    input  logic             snoop_sts_tready,
    input  logic [3:0]       dmw_status,
    input  logic             soft_clear,
    output logic             layer_busy,
    output logic             layer_done,
    output logic             layer_err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] sts_count
);

    seq_state_t       state_q, state_d;
    desc_t            desc_in, desc_q;
    logic [CNT_W-1:0] sts_count_q, count_inc, exp_cnt;
    logic [19:0]      exp_prod;
    logic [2:0]       err_code_q, err_code_d, new_code;
    logic             layer_err_q, layer_err_d, new_err;
    logic             out_en_q, cfg0_armed_q;
    logic             desc_hs, cfg_hs, sts_hs, desc_ok, sts_bad, last_sts;
    logic             wd_en, wd_kick, wd_expired;
    logic             unused_sts_low;

    assign desc_in = s_axis_desc_tdata;
    assign desc_hs = s_axis_desc_tvalid && s_axis_desc_tready;
    assign cfg_hs  = m_axis_dmwconfig_tvalid && m_axis_dmwconfig_tready;
    assign sts_hs  = snoop_sts_tvalid && snoop_sts_tready;

    // A layer needs rows, tiles, width and at least 8 output channels per tile
    assign desc_ok = (calc_h_eff(desc_in.word0[28], desc_in.word1[23:12]) != 12'd0)
                  && (desc_in.word1[31:24] != 8'd0)
                  && (desc_in.word1[11:0]  != 12'd0)
                  && (desc_in.word0[27:15] != 13'd0);

    assign exp_prod  = 20'(calc_h_eff(desc_q.word0[28], desc_q.word1[23:12])) * 20'(desc_q.word1[31:24]);
    assign exp_cnt   = CNT_W'(exp_prod);
    assign count_inc = (sts_count_q == '1) ? sts_count_q : sts_count_q + CNT_W'(1);
    assign sts_bad   = !snoop_sts_tdata[STS_OKAY_BIT] || (snoop_sts_tdata[STS_ERR_HI:STS_ERR_LO] != 3'd0);
    assign last_sts  = (state_q == ST_RUN) && sts_hs && (count_inc == exp_cnt);
    assign unused_sts_low = ^snoop_sts_tdata[3:0];

    // Watchdog only runs while a layer is in flight; any handshake is progress
    assign wd_en   = state_q inside {ST_CFG0, ST_CFG1, ST_CFG2, ST_RUN};
    assign wd_kick = cfg_hs || sts_hs || !wd_en;

    dmw_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .kick    (wd_kick),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // Next state, handshake outputs and error events for this cycle
    always_comb begin
        state_d                 = state_q;
        s_axis_desc_tready      = 1'b0;
        m_axis_dmwconfig_tvalid = 1'b0;
        m_axis_dmwconfig_tdata  = desc_q.word0;
        new_err                 = 1'b0;
        new_code                = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                s_axis_desc_tready = out_en_q;
                if (sts_hs) begin
                    new_err  = 1'b1;
                    new_code = ERR_STRAY;
                end
                if (desc_hs) begin
                    if (desc_ok) begin
                        state_d = ST_CFG0;
                    end else begin
                        new_err  = 1'b1;
                        new_code = ERR_BAD_DESC;
                    end
                end
            end
            ST_CFG0: begin
                // Once offered, word0 stays valid even if the mover leaves CONFIG
                m_axis_dmwconfig_tvalid = (dmw_status == DMW_ST_CONFIG) || cfg0_armed_q;
                if (cfg_hs) state_d = ST_CFG1;
            end
            ST_CFG1: begin
                m_axis_dmwconfig_tdata  = desc_q.word1;
                m_axis_dmwconfig_tvalid = 1'b1;
                if (cfg_hs) state_d = ST_CFG2;
            end
            ST_CFG2: begin
                m_axis_dmwconfig_tdata  = desc_q.word2;
                m_axis_dmwconfig_tvalid = 1'b1;
                if (cfg_hs) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (sts_hs && sts_bad) begin
                    new_err  = 1'b1;
                    new_code = ERR_STS;
                end
                if (last_sts) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (sts_hs) begin
                    new_err  = 1'b1;
                    new_code = ERR_STRAY;
                end
            end
            ST_ERR: begin
                if (soft_clear) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wd_expired) begin
            state_d  = ST_ERR;
            new_err  = 1'b1;
            new_code = ERR_TIMEOUT;
        end
    end

    // First error wins until soft_clear; an error in the clearing cycle still lands
    always_comb begin
        err_code_d  = soft_clear ? ERR_NONE : err_code_q;
        layer_err_d = soft_clear ? 1'b0 : layer_err_q;
        if (new_err) begin
            layer_err_d = 1'b1;
            if (err_code_d == ERR_NONE) err_code_d = new_code;
        end
    end

    // State, descriptor latch, completion counter and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            desc_q       <= '0;
            sts_count_q  <= '0;
            err_code_q   <= ERR_NONE;
            layer_err_q  <= 1'b0;
            out_en_q     <= 1'b0;
            cfg0_armed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_code_q   <= err_code_d;
            layer_err_q  <= layer_err_d;
            out_en_q     <= 1'b1;
            cfg0_armed_q <= (state_q == ST_CFG0) && m_axis_dmwconfig_tvalid && !m_axis_dmwconfig_tready;
            if ((state_q == ST_IDLE) && desc_hs && desc_ok) begin
                desc_q      <= desc_in;
                sts_count_q <= '0;
            end else if ((state_q == ST_RUN) && sts_hs) begin
                sts_count_q <= count_inc;
            end
        end
    end

    assign layer_busy = (state_q inside {ST_CFG0, ST_CFG1, ST_CFG2, ST_RUN, ST_ERR});
    assign layer_done = (state_q == ST_DONE);
    assign layer_err  = layer_err_q;
    assign err_code   = err_code_q;
    assign sts_count  = sts_count_q;

endmodule

// File: tb/tb_dmw_layer_sequencer.sv
// Self-checking bench for the layer sequencer with a field-level reference model.
// Latency: n/a.
// Backpressure: exercises config backpressure and mover-state stalls.
module tb_dmw_layer_sequencer;

    localparam int CNT_W = 20;
    localparam int TMO   = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [95:0]      s_desc_tdata = '0;
    logic             s_desc_tvalid = 1'b0;
    logic             s_desc_tready;
    logic [31:0]      m_tdata;
    logic             m_tvalid;
    logic             m_tready = 1'b0;
    logic [7:0]       snoop_tdata = '0;
    logic             snoop_tvalid = 1'b0;
    logic             snoop_tready = 1'b0;
    logic [3:0]       dmw_status = '0;
    logic             soft_clear = 1'b0;
    logic             layer_busy, layer_done, layer_err;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] sts_count;

    always #5 clk = ~clk;

    dmw_layer_sequencer #(.TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .s_axis_desc_tdata       (s_desc_tdata),
        .s_axis_desc_tvalid      (s_desc_tvalid),
        .s_axis_desc_tready      (s_desc_tready),
        .m_axis_dmwconfig_tdata  (m_tdata),
        .m_axis_dmwconfig_tvalid (m_tvalid),
        .m_axis_dmwconfig_tready (m_tready),
        .snoop_sts_tdata         (snoop_tdata),
        .snoop_sts_tvalid        (snoop_tvalid),
        .snoop_sts_tready        (snoop_tready),
        .dmw_status              (dmw_status),
        .soft_clear              (soft_clear),
        .layer_busy              (layer_busy),
        .layer_done              (layer_done),
        .layer_err               (layer_err),
        .err_code                (err_code),
        .sts_count               (sts_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observations gathered by the stimulus tasks
    logic [31:0]      cap_q[$];
    logic [7:0]       sts_list[$];
    int               cfg_iters, hold_viol, early_vld, early_done;
    bit               desc_hs_ok;
    logic             done_m1, done_m2, rdy_m2, lerr_m1;
    logic [2:0]       code_m1;
    logic [CNT_W-1:0] cnt_m1;

    // Reference: completions = rows (halved when subsampling) times tiles
    function automatic int model_expected(input logic [31:0] w0, input logic [31:0] w1);
        int h;
        h = int'(w1[23:12]);
        if (w0[28]) h = h / 2;
        return h * int'(w1[31:24]);
    endfunction

    // All stimulus tasks start and end at a falling edge
    task automatic send_desc(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        desc_hs_ok   = 1'b0;
        s_desc_tdata = {w2, w1, w0};
        for (int g = 0; g < 50 && !desc_hs_ok; g++) begin
            s_desc_tvalid = 1'b1;
            #1;
            if (s_desc_tready) desc_hs_ok = 1'b1;
            @(negedge clk);
        end
        s_desc_tvalid = 1'b0;
    endtask

    task automatic run_config(input int rdy_mode, input int stall);
        logic        pv, ph;
        logic [31:0] pd;
        int          left;
        cap_q.delete();
        hold_viol = 0; early_vld = 0; cfg_iters = 0;
        pv = 1'b0; ph = 1'b0; pd = '0; left = stall;
        for (int it = 0; it < 200 && cap_q.size() < 3; it++) begin
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = it[0];
                default: m_tready = 1'($urandom % 2);
            endcase
            dmw_status = (left > 0) ? 4'b0100 : 4'b0000;
            if (left > 0) left--;
            #1;
            if (dmw_status != 4'b0000 && m_tvalid) early_vld++;
            if (pv && !ph && (m_tvalid !== 1'b1 || m_tdata !== pd)) hold_viol++;
            pv = m_tvalid; pd = m_tdata; ph = m_tvalid && m_tready;
            if (ph) cap_q.push_back(m_tdata);
            cfg_iters++;
            @(negedge clk);
        end
        m_tready   = 1'b0;
        dmw_status = 4'b0000;
    endtask

    task automatic send_statuses(input int n);
        early_done = 0;
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                snoop_tvalid = 1'($urandom % 2);
                snoop_tready = snoop_tvalid ? 1'b0 : 1'($urandom % 2);
                snoop_tdata  = 8'($urandom);
                #1;
                if (layer_done) early_done++;
                @(negedge clk);
            end
            snoop_tvalid = 1'b1; snoop_tready = 1'b1; snoop_tdata = sts_list[i];
            #1;
            if (layer_done) early_done++;
            @(negedge clk);
        end
        snoop_tvalid = 1'b0; snoop_tready = 1'b0;
        #1;
        done_m1 = layer_done; cnt_m1 = sts_count; code_m1 = err_code; lerr_m1 = layer_err;
        @(negedge clk);
        #1;
        done_m2 = layer_done; rdy_m2 = s_desc_tready;
        @(negedge clk);
    endtask

    task automatic pulse_soft_clear();
        soft_clear = 1'b1;
        @(negedge clk);
        soft_clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (s_desc_tready !== 1'b0) $display("FAIL rst_tready: got %b want 0", s_desc_tready); else n_pass++;
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_tvalid); else n_pass++;
        n_checks++; if (layer_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", layer_busy); else n_pass++;
        n_checks++; if (layer_done !== 1'b0) $display("FAIL rst_done: got %b want 0", layer_done); else n_pass++;
        n_checks++; if (layer_err !== 1'b0) $display("FAIL rst_err: got %b want 0", layer_err); else n_pass++;
        n_checks++; if (err_code !== 3'd0) $display("FAIL rst_code: got %0d want 0", err_code); else n_pass++;
        n_checks++; if (sts_count !== '0) $display("FAIL rst_count: got %0d want 0", sts_count); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (s_desc_tready !== 1'b1) $display("FAIL rst_first_tready: got %b want 1", s_desc_tready); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        logic [31:0] w0, w1, w2;
        w0 = 32'h0001_0002; w1 = 32'h0200_4008; w2 = 32'h8000_0000;
        send_desc(w0, w1, w2);
        run_config(0, 0);
        sts_list.delete();
        repeat (8) sts_list.push_back(8'h80);
        send_statuses(model_expected(w0, w1));
        n_checks++; if (desc_hs_ok !== 1'b1) $display("FAIL nom_desc_accept: got %b want 1", desc_hs_ok); else n_pass++;
        n_checks++; if (cap_q.size() !== 3) $display("FAIL nom_nwords: got %0d want 3", cap_q.size()); else n_pass++;
        n_checks++; if (cap_q[0] !== w0) $display("FAIL nom_word0: got %h want %h", cap_q[0], w0); else n_pass++;
        n_checks++; if (cap_q[1] !== w1) $display("FAIL nom_word1: got %h want %h", cap_q[1], w1); else n_pass++;
        n_checks++; if (cap_q[2] !== w2) $display("FAIL nom_word2: got %h want %h", cap_q[2], w2); else n_pass++;
        n_checks++; if (cfg_iters !== 3) $display("FAIL nom_cfg_cycles: got %0d want 3", cfg_iters); else n_pass++;
        n_checks++; if (early_done !== 0) $display("FAIL nom_early_done: got %0d want 0", early_done); else n_pass++;
        n_checks++; if (done_m1 !== 1'b1) $display("FAIL nom_done: got %b want 1", done_m1); else n_pass++;
        n_checks++; if (cnt_m1 !== 20'd8) $display("FAIL nom_count: got %0d want 8", cnt_m1); else n_pass++;
        n_checks++; if (lerr_m1 !== 1'b0) $display("FAIL nom_err: got %b want 0", lerr_m1); else n_pass++;
        n_checks++; if (done_m2 !== 1'b0) $display("FAIL nom_done_width: got %b want 0", done_m2); else n_pass++;
        n_checks++; if (rdy_m2 !== 1'b1) $display("FAIL nom_tready_after: got %b want 1", rdy_m2); else n_pass++;
    endtask

    task automatic test_sampling();
        logic [31:0] w0, w1;
        w0 = 32'h1001_0002; w1 = 32'h0200_4008;
        send_desc(w0, w1, 32'h1234_5678);
        run_config(0, 0);
        sts_list.delete();
        repeat (8) sts_list.push_back(8'h81);
        send_statuses(model_expected(w0, w1));
        n_checks++; if (early_done !== 0) $display("FAIL smp_early_done: got %0d want 0", early_done); else n_pass++;
        n_checks++; if (done_m1 !== 1'b1) $display("FAIL smp_done: got %b want 1", done_m1); else n_pass++;
        n_checks++; if (cnt_m1 !== 20'd4) $display("FAIL smp_count: got %0d want 4", cnt_m1); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] w0, w1, w2;
        w0 = 32'h0001_0002; w1 = 32'h0200_4008; w2 = 32'hCAFE_0040;
        send_desc(w0, w1, w2);
        run_config(1, 5);
        n_checks++; if (early_vld !== 0) $display("FAIL bp_valid_in_stall: got %0d want 0", early_vld); else n_pass++;
        n_checks++; if (hold_viol !== 0) $display("FAIL bp_hold: got %0d want 0", hold_viol); else n_pass++;
        n_checks++; if (cap_q.size() !== 3) $display("FAIL bp_nwords: got %0d want 3", cap_q.size()); else n_pass++;
        n_checks++; if (cap_q[0] !== w0 || cap_q[1] !== w1 || cap_q[2] !== w2)
            $display("FAIL bp_order: got %h %h %h want %h %h %h", cap_q[0], cap_q[1], cap_q[2], w0, w1, w2); else n_pass++;
        sts_list.delete();
        repeat (8) sts_list.push_back(8'h80);
        send_statuses(model_expected(w0, w1));
        n_checks++; if (done_m1 !== 1'b1) $display("FAIL bp_done: got %b want 1", done_m1); else n_pass++;
    endtask

    task automatic test_status_error();
        logic [31:0] w0, w1;
        w0 = 32'h0001_0002; w1 = 32'h0200_4008;
        send_desc(w0, w1, 32'h0);
        run_config(0, 0);
        sts_list.delete();
        repeat (8) sts_list.push_back(8'h80);
        sts_list[2] = 8'hA0;
        send_statuses(model_expected(w0, w1));
        n_checks++; if (code_m1 !== 3'd2) $display("FAIL sterr_code: got %0d want 2", code_m1); else n_pass++;
        n_checks++; if (lerr_m1 !== 1'b1) $display("FAIL sterr_flag: got %b want 1", lerr_m1); else n_pass++;
        n_checks++; if (done_m1 !== 1'b1) $display("FAIL sterr_done: got %b want 1", done_m1); else n_pass++;
        n_checks++; if (cnt_m1 !== 20'd8) $display("FAIL sterr_count: got %0d want 8", cnt_m1); else n_pass++;
        pulse_soft_clear();
        #1;
        n_checks++; if (err_code !== 3'd0 || layer_err !== 1'b0)
            $display("FAIL sterr_clear: got code %0d err %b want 0 0", err_code, layer_err); else n_pass++;
        n_checks++; if (s_desc_tready !== 1'b1) $display("FAIL sterr_idle_tready: got %b want 1", s_desc_tready); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            logic        sw;
            logic [11:0] ih, iw, grp;
            logic [7:0]  wt, s;
            logic [15:0] perw;
            logic [31:0] w0, w1, w2;
            int          exp_n;
            bit          any_bad;
            pulse_soft_clear();
            sw   = 1'($urandom % 2);
            ih   = sw ? 12'($urandom_range(2, 9)) : 12'($urandom_range(1, 5));
            wt   = 8'($urandom_range(1, 3));
            iw   = 12'($urandom_range(1, 4095));
            perw = 16'($urandom_range(8, 65535));
            grp  = 12'($urandom);
            w0 = {3'b000, sw, perw, grp};
            w1 = {wt, ih, iw};
            w2 = $urandom;
            exp_n = model_expected(w0, w1);
            any_bad = 1'b0;
            sts_list.delete();
            for (int i = 0; i < exp_n; i++) begin
                if ($urandom % 5 == 0) begin
                    any_bad = 1'b1;
                    s = ($urandom % 2 == 1) ? {1'b0, 7'($urandom)} : (8'h80 | (8'h10 << $urandom_range(0, 2)));
                end else begin
                    s = 8'h80 | 8'($urandom % 16);
                end
                sts_list.push_back(s);
            end
            send_desc(w0, w1, w2);
            run_config(2, $urandom_range(0, 3));
            send_statuses(exp_n);
            n_checks++; if (cap_q.size() !== 3 || cap_q[0] !== w0 || cap_q[1] !== w1 || cap_q[2] !== w2)
                $display("FAIL rnd%0d_words: got %0d words %h %h %h want %h %h %h", k, cap_q.size(), cap_q[0], cap_q[1], cap_q[2], w0, w1, w2); else n_pass++;
            n_checks++; if (done_m1 !== 1'b1 || early_done !== 0)
                $display("FAIL rnd%0d_done: got done %b early %0d want 1 0", k, done_m1, early_done); else n_pass++;
            n_checks++; if (cnt_m1 !== CNT_W'(exp_n)) $display("FAIL rnd%0d_count: got %0d want %0d", k, cnt_m1, exp_n); else n_pass++;
            n_checks++; if (code_m1 !== (any_bad ? 3'd2 : 3'd0))
                $display("FAIL rnd%0d_code: got %0d want %0d", k, code_m1, any_bad ? 2 : 0); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int n;
        pulse_soft_clear();
        send_desc(32'h0001_0002, 32'h0200_4008, 32'h0);
        run_config(0, 0);
        #1;
        n = 0;
        while (!layer_err && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++; if (n !== TMO) $display("FAIL tmo_cycles: got %0d want %0d", n, TMO); else n_pass++;
        n_checks++; if (err_code !== 3'd3) $display("FAIL tmo_code: got %0d want 3", err_code); else n_pass++;
        n_checks++; if (layer_busy !== 1'b1 || s_desc_tready !== 1'b0 || m_tvalid !== 1'b0)
            $display("FAIL tmo_err_state: got busy %b tready %b tvalid %b want 1 0 0", layer_busy, s_desc_tready, m_tvalid); else n_pass++;
        @(negedge clk);
        pulse_soft_clear();
        #1;
        n_checks++; if (s_desc_tready !== 1'b1 || err_code !== 3'd0 || layer_busy !== 1'b0)
            $display("FAIL tmo_clear: got tready %b code %0d busy %b want 1 0 0", s_desc_tready, err_code, layer_busy); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int d;
        send_desc(32'h0001_0002, 32'h0200_4008, 32'h0);
        run_config(0, 0);
        repeat (2) begin
            snoop_tvalid = 1'b1; snoop_tready = 1'b1; snoop_tdata = 8'h80;
            @(negedge clk);
        end
        snoop_tvalid = 1'b0; snoop_tready = 1'b0;
        #1;
        n_checks++; if (sts_count !== 20'd2) $display("FAIL mid_count: got %0d want 2", sts_count); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (layer_busy !== 1'b0 || sts_count !== '0 || layer_done !== 1'b0)
            $display("FAIL mid_reset: got busy %b count %0d done %b want 0 0 0", layer_busy, sts_count, layer_done); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        d = 0;
        repeat (4) begin
            #1;
            if (layer_done) d++;
            @(negedge clk);
        end
        #1;
        n_checks++; if (d !== 0 || s_desc_tready !== 1'b1)
            $display("FAIL mid_after: got done %0d tready %b want 0 1", d, s_desc_tready); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_bad_desc_stray();
        int v;
        send_desc(32'h0001_0002, 32'h0000_4008, 32'h0);
        #1;
        n_checks++; if (err_code !== 3'd1 || layer_err !== 1'b1)
            $display("FAIL bad_code: got code %0d err %b want 1 1", err_code, layer_err); else n_pass++;
        n_checks++; if (s_desc_tready !== 1'b1 || layer_busy !== 1'b0)
            $display("FAIL bad_idle: got tready %b busy %b want 1 0", s_desc_tready, layer_busy); else n_pass++;
        @(negedge clk);
        v = 0;
        repeat (3) begin
            #1;
            if (m_tvalid) v++;
            @(negedge clk);
        end
        n_checks++; if (v !== 0) $display("FAIL bad_no_cfg: got %0d valid cycles want 0", v); else n_pass++;
        snoop_tvalid = 1'b1; snoop_tready = 1'b1; snoop_tdata = 8'h80;
        @(negedge clk);
        snoop_tvalid = 1'b0; snoop_tready = 1'b0;
        #1;
        n_checks++; if (err_code !== 3'd1 || sts_count !== '0)
            $display("FAIL stray_keep: got code %0d count %0d want 1 0", err_code, sts_count); else n_pass++;
        @(negedge clk);
        pulse_soft_clear();
        snoop_tvalid = 1'b1; snoop_tready = 1'b1;
        @(negedge clk);
        snoop_tvalid = 1'b0; snoop_tready = 1'b0;
        #1;
        n_checks++; if (err_code !== 3'd4 || layer_err !== 1'b1 || sts_count !== '0)
            $display("FAIL stray_code: got code %0d err %b count %0d want 4 1 0", err_code, layer_err, sts_count); else n_pass++;
        @(negedge clk);
        pulse_soft_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        test_reset();
        test_nominal();
        test_sampling();
        test_backpressure();
        test_status_error();
        test_random();
        test_timeout();
        test_mid_reset();
        test_bad_desc_stray();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
